// File: rtl/star_scroll_ctrl_pkg.sv
// Shared types and constants for the star-layer scroll scheduler.
// Game-state codes come from the game logic; scroll modes are the controller's FSM states.
package star_scroll_ctrl_pkg;

    localparam int STEP_W = 5;

    localparam logic [1:0] GAME_START = 2'd0;
    localparam logic [1:0] GAME_PLAY  = 2'd1;
    localparam logic [1:0] GAME_WARP  = 2'd2;
    localparam logic [1:0] GAME_OVER  = 2'd3;

    typedef enum logic [2:0] {
        FREEZE,
        DRIFT,
        CRUISE,
        WARP_UP,
        WARP_HOLD,
        WARP_DOWN,
        FADE,
        DARK
    } scroll_mode_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/star_scroll_ctrl_if.sv
// Bundle between game-state logic, the scroll controller and star_background.
// master = the scroll controller; slave = its environment.
interface star_scroll_ctrl_if;
    import star_scroll_ctrl_pkg::*;

    logic              fsync;
    logic [1:0]        game_state;
    logic              upd_ack;
    logic              upd_req;
    logic [STEP_W-1:0] upd_step;
    logic              star_en;
    logic [7:0]        brightness;
    logic [2:0]        twinkle_phase;
    logic [7:0]        overrun_cnt;
    scroll_mode_t      mode;

    modport master (
        input  fsync, game_state, upd_ack,
        output upd_req, upd_step, star_en, brightness, twinkle_phase, overrun_cnt, mode
    );

    modport slave (
        output fsync, game_state, upd_ack,
        input  upd_req, upd_step, star_en, brightness, twinkle_phase, overrun_cnt, mode
    );

endinterface

// File: rtl/star_scroll_ctrl_frame_req_hs.sv
// Holds the per-frame update request until star_background acks it; a frame arriving
// while the previous request is still pending is merged into it (saturating) and counted.
module star_scroll_ctrl_frame_req_hs
    import star_scroll_ctrl_pkg::*;
(
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic              i_fsync,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_ack,
    output logic              o_req,
    output logic [STEP_W-1:0] o_step,
    output logic [7:0]        o_overrun
);

    logic              r_req;
    logic [STEP_W-1:0] r_step;
    logic [7:0]        r_overrun;
    logic [STEP_W:0]   w_sum;
    logic [STEP_W-1:0] w_merged;

    assign w_sum    = {1'b0, r_step} + {1'b0, i_step};
    assign w_merged = w_sum[STEP_W] ? {STEP_W{1'b1}} : w_sum[STEP_W-1:0];

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_req     <= 1'b0;
            r_step    <= '0;
            r_overrun <= 8'd0;
        end else if (i_fsync && (i_step != '0)) begin
            // An ack in the same cycle retires the old request, so the new frame starts fresh.
            if (!r_req || i_ack) begin
                r_req  <= 1'b1;
                r_step <= i_step;
            end else begin
                r_step    <= w_merged;
                r_overrun <= sat_inc8(r_overrun);
            end
        end else if (i_ack) begin
            r_req <= 1'b0;
        end
    end

    assign o_req     = r_req;
    assign o_step    = r_step;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/star_scroll_ctrl.sv
// Per-frame star-layer scheduler: scroll-mode FSM, warp ramping, fade-out and twinkle phase,
// all advanced only on fsync; the frame's step is handed to the request holder.
module star_scroll_ctrl
    import star_scroll_ctrl_pkg::*;
#(
    parameter int CRUISE_STEP    = 2,
    parameter int MAX_STEP       = 12,
    parameter int RAMP_FRAMES    = 4,
    parameter int FADE_STEP      = 8,
    parameter int TWINKLE_FRAMES = 8
) (
    input  logic pixel_clk,
    input  logic rst,
    star_scroll_ctrl_if.master bus
);

    scroll_mode_t      r_mode;
    logic [STEP_W-1:0] r_level;
    logic [7:0]        r_ramp_cnt;
    logic              r_drift_ph;
    logic [7:0]        r_bright;
    logic              r_star_en;
    logic [7:0]        r_twk_cnt;
    logic [2:0]        r_twk_phase;

    scroll_mode_t      w_mode_next;
    logic [STEP_W-1:0] w_level_next;
    logic [7:0]        w_ramp_next;
    logic              w_drift_next;
    logic [7:0]        w_bright_next;
    logic              w_en_next;
    logic [STEP_W-1:0] w_frame_step;

    logic [7:0]        w_ramp_inc;
    logic              w_ramp_wrap;
    logic [STEP_W-1:0] w_level_up;
    logic [STEP_W-1:0] w_level_dn;
    logic [7:0]        w_bright_dec;
    logic [7:0]        w_twk_inc;
    logic              w_req;
    logic [STEP_W-1:0] w_step;
    logic [7:0]        w_overrun;

    assign w_ramp_inc   = r_ramp_cnt + 8'd1;
    assign w_ramp_wrap  = (w_ramp_inc == 8'(RAMP_FRAMES));
    assign w_level_up   = r_level + STEP_W'(1);
    assign w_level_dn   = r_level - STEP_W'(1);
    assign w_bright_dec = (r_bright > 8'(FADE_STEP)) ? r_bright - 8'(FADE_STEP) : 8'd0;
    assign w_twk_inc    = r_twk_cnt + 8'd1;

    always_comb begin
        w_mode_next   = r_mode;
        w_level_next  = r_level;
        w_ramp_next   = r_ramp_cnt;
        w_drift_next  = r_drift_ph;
        w_bright_next = r_bright;
        w_en_next     = r_star_en;
        if (bus.game_state == GAME_OVER && r_mode != FADE && r_mode != DARK) begin
            w_bright_next = w_bright_dec;
            w_mode_next   = (w_bright_dec == 8'd0) ? DARK : FADE;
            w_en_next     = (w_bright_dec != 8'd0);
            w_ramp_next   = 8'd0;
        end else begin
            case (r_mode)
                FREEZE: begin
                    if (bus.game_state == GAME_START) begin
                        w_mode_next  = DRIFT;
                        w_drift_next = 1'b1;
                    end else if (bus.game_state == GAME_PLAY) begin
                        w_mode_next  = CRUISE;
                        w_level_next = STEP_W'(CRUISE_STEP);
                    end else if (bus.game_state == GAME_WARP) begin
                        w_mode_next  = WARP_UP;
                        w_level_next = STEP_W'(CRUISE_STEP);
                        w_ramp_next  = 8'd0;
                    end
                end
                DRIFT: begin
                    if (bus.game_state == GAME_PLAY) begin
                        w_mode_next  = CRUISE;
                        w_level_next = STEP_W'(CRUISE_STEP);
                    end else begin
                        w_drift_next = ~r_drift_ph;
                    end
                end
                CRUISE: begin
                    if (bus.game_state == GAME_WARP) begin
                        w_mode_next  = WARP_UP;
                        w_level_next = STEP_W'(CRUISE_STEP);
                        w_ramp_next  = 8'd0;
                    end else if (bus.game_state == GAME_START) begin
                        w_mode_next  = DRIFT;
                        w_drift_next = 1'b1;
                    end
                end
                WARP_UP: begin
                    if (bus.game_state == GAME_WARP) begin
                        if (w_ramp_wrap) begin
                            w_level_next = w_level_up;
                            w_ramp_next  = 8'd0;
                            if (w_level_up >= STEP_W'(MAX_STEP)) w_mode_next = WARP_HOLD;
                        end else begin
                            w_ramp_next = w_ramp_inc;
                        end
                    end else begin
                        // Warp aborted before any climb: nothing to ramp down from.
                        w_ramp_next = 8'd0;
                        if (r_level <= STEP_W'(CRUISE_STEP)) begin
                            w_mode_next  = CRUISE;
                            w_level_next = STEP_W'(CRUISE_STEP);
                        end else begin
                            w_mode_next = WARP_DOWN;
                        end
                    end
                end
                WARP_HOLD: begin
                    if (bus.game_state != GAME_WARP) begin
                        w_mode_next = WARP_DOWN;
                        w_ramp_next = 8'd0;
                    end
                end
                WARP_DOWN: begin
                    if (bus.game_state == GAME_WARP) begin
                        w_mode_next = WARP_UP;
                        w_ramp_next = 8'd0;
                    end else if (w_ramp_wrap) begin
                        w_level_next = w_level_dn;
                        w_ramp_next  = 8'd0;
                        if (w_level_dn <= STEP_W'(CRUISE_STEP)) begin
                            w_mode_next  = CRUISE;
                            w_level_next = STEP_W'(CRUISE_STEP);
                        end
                    end else begin
                        w_ramp_next = w_ramp_inc;
                    end
                end
                FADE: begin
                    w_bright_next = w_bright_dec;
                    if (w_bright_dec == 8'd0) begin
                        w_mode_next = DARK;
                        w_en_next   = 1'b0;
                    end
                end
                DARK: begin
                    if (bus.game_state == GAME_START) begin
                        w_mode_next   = DRIFT;
                        w_drift_next  = 1'b1;
                        w_bright_next = 8'd255;
                        w_en_next     = 1'b1;
                    end else if (bus.game_state == GAME_PLAY) begin
                        w_mode_next   = CRUISE;
                        w_level_next  = STEP_W'(CRUISE_STEP);
                        w_bright_next = 8'd255;
                        w_en_next     = 1'b1;
                    end
                end
                default: w_mode_next = FREEZE;
            endcase
        end
    end

    // The frame's step is that of the state being entered, so a transition takes effect at once.
    always_comb begin
        case (w_mode_next)
            DRIFT:                        w_frame_step = {{(STEP_W-1){1'b0}}, w_drift_next};
            CRUISE:                       w_frame_step = STEP_W'(CRUISE_STEP);
            WARP_UP, WARP_HOLD, WARP_DOWN: w_frame_step = w_level_next;
            default:                      w_frame_step = '0;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_mode      <= FREEZE;
            r_level     <= '0;
            r_ramp_cnt  <= 8'd0;
            r_drift_ph  <= 1'b0;
            r_bright    <= 8'd255;
            r_star_en   <= 1'b1;
            r_twk_cnt   <= 8'd0;
            r_twk_phase <= 3'd0;
        end else if (bus.fsync) begin
            r_mode     <= w_mode_next;
            r_level    <= w_level_next;
            r_ramp_cnt <= w_ramp_next;
            r_drift_ph <= w_drift_next;
            r_bright   <= w_bright_next;
            r_star_en  <= w_en_next;
            if (w_twk_inc == 8'(TWINKLE_FRAMES)) begin
                r_twk_cnt   <= 8'd0;
                r_twk_phase <= r_twk_phase + 3'd1;
            end else begin
                r_twk_cnt <= w_twk_inc;
            end
        end
    end

    star_scroll_ctrl_frame_req_hs u_req_hs (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .i_fsync   (bus.fsync),
        .i_step    (w_frame_step),
        .i_ack     (bus.upd_ack),
        .o_req     (w_req),
        .o_step    (w_step),
        .o_overrun (w_overrun)
    );

    assign bus.upd_req       = w_req;
    assign bus.upd_step      = w_step;
    assign bus.overrun_cnt   = w_overrun;
    assign bus.star_en       = r_star_en;
    assign bus.brightness    = r_bright;
    assign bus.twinkle_phase = r_twk_phase;
    assign bus.mode          = r_mode;

endmodule

// File: tb/tb_star_scroll_ctrl.sv
// Directed bench for star_scroll_ctrl: a frame-level reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_star_scroll_ctrl;
    import star_scroll_ctrl_pkg::*;

    localparam int CRUISE_STEP    = 2;
    localparam int MAX_STEP       = 12;
    localparam int RAMP_FRAMES    = 4;
    localparam int FADE_STEP      = 8;
    localparam int TWINKLE_FRAMES = 8;
    localparam int STEP_SAT       = 31;

    logic clk;
    logic rst;
    star_scroll_ctrl_if bus();

    star_scroll_ctrl dut (
        .pixel_clk (clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: ramps are expressed as frames elapsed since entering the state.
    scroll_mode_t m_mode;
    int m_k, m_base, m_bri, m_fs, m_ustep, m_ov, m_nfs;
    bit m_en, m_req;

    task automatic m_reset();
        m_mode = FREEZE; m_k = 0; m_base = 0; m_bri = 255; m_en = 1'b1;
        m_req = 1'b0; m_ustep = 0; m_ov = 0; m_nfs = 0;
    endtask

    task automatic m_goto(input scroll_mode_t md, input int base);
        m_mode = md; m_base = base; m_k = 0;
    endtask

    function automatic int m_lvl();
        case (m_mode)
            WARP_UP:   return m_base + m_k / RAMP_FRAMES;
            WARP_DOWN: return m_base - m_k / RAMP_FRAMES;
            WARP_HOLD: return MAX_STEP;
            default:   return CRUISE_STEP;
        endcase
    endfunction

    task automatic m_down(input int lvl);
        if (lvl <= CRUISE_STEP) m_goto(CRUISE, 0);
        else m_goto(WARP_DOWN, lvl);
    endtask

    task automatic m_frame(input logic [1:0] gs, output int fs);
        int lvl;
        lvl = m_lvl();
        if (gs == GAME_OVER && m_mode != FADE && m_mode != DARK) begin
            m_bri = m_bri - FADE_STEP;
            if (m_bri < 0) m_bri = 0;
            m_goto(m_bri == 0 ? DARK : FADE, 0);
            if (m_bri == 0) m_en = 1'b0;
        end else begin
            case (m_mode)
                FREEZE: if (gs == GAME_START) m_goto(DRIFT, 0);
                        else if (gs == GAME_PLAY) m_goto(CRUISE, 0);
                        else if (gs == GAME_WARP) m_goto(WARP_UP, CRUISE_STEP);
                DRIFT:  if (gs == GAME_PLAY) m_goto(CRUISE, 0); else m_k++;
                CRUISE: if (gs == GAME_WARP) m_goto(WARP_UP, CRUISE_STEP);
                        else if (gs == GAME_START) m_goto(DRIFT, 0);
                WARP_UP: if (gs == GAME_WARP) begin
                            m_k++;
                            if (m_lvl() >= MAX_STEP) m_goto(WARP_HOLD, MAX_STEP);
                         end else m_down(lvl);
                WARP_HOLD: if (gs != GAME_WARP) m_down(lvl);
                WARP_DOWN: if (gs == GAME_WARP) m_goto(WARP_UP, lvl);
                           else begin
                               m_k++;
                               if (m_lvl() <= CRUISE_STEP) m_goto(CRUISE, 0);
                           end
                FADE: begin
                    m_bri = m_bri - FADE_STEP;
                    if (m_bri <= 0) begin m_bri = 0; m_goto(DARK, 0); m_en = 1'b0; end
                end
                DARK: if (gs == GAME_START || gs == GAME_PLAY) begin
                          m_goto(gs == GAME_START ? DRIFT : CRUISE, 0);
                          m_bri = 255; m_en = 1'b1;
                      end
                default: ;
            endcase
        end
        case (m_mode)
            DRIFT:                         fs = (m_k % 2 == 0) ? 1 : 0;
            CRUISE:                        fs = CRUISE_STEP;
            WARP_UP, WARP_HOLD, WARP_DOWN: fs = m_lvl();
            default:                       fs = 0;
        endcase
    endtask

    always @(posedge clk) begin
        if (rst) m_reset();
        else begin
            m_fs = 0;
            if (bus.fsync) begin
                m_frame(bus.game_state, m_fs);
                m_nfs++;
            end
            if (bus.fsync && m_fs != 0) begin
                if (!m_req || bus.upd_ack) begin
                    m_req = 1'b1; m_ustep = m_fs;
                end else begin
                    m_ustep = (m_ustep + m_fs > STEP_SAT) ? STEP_SAT : m_ustep + m_fs;
                    if (m_ov < 255) m_ov++;
                end
            end else if (bus.upd_ack) m_req = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mode",        int'(bus.mode),          int'(m_mode));
            chk("upd_req",     int'(bus.upd_req),       int'(m_req));
            chk("upd_step",    int'(bus.upd_step),      m_ustep);
            chk("star_en",     int'(bus.star_en),       int'(m_en));
            chk("brightness",  int'(bus.brightness),    m_bri);
            chk("twinkle",     int'(bus.twinkle_phase), (m_nfs / TWINKLE_FRAMES) % 8);
            chk("overrun_cnt", int'(bus.overrun_cnt),   m_ov);
        end
    end

    task automatic cycle(input bit fs, input logic [1:0] gs, input bit ack);
        bus.fsync = fs; bus.game_state = gs; bus.upd_ack = ack;
        @(posedge clk); #1;
    endtask

    task automatic frame(input logic [1:0] gs, input bit ack);
        cycle(1'b1, gs, 1'b0);
        cycle(1'b0, gs, ack);
        cycle(1'b0, gs, 1'b0);
        cycle(1'b0, gs, 1'b0);
    endtask

    task automatic lit_reset(input string tag);
        chk({tag, "_mode"},    int'(bus.mode), int'(FREEZE));
        chk({tag, "_req"},     int'(bus.upd_req), 0);
        chk({tag, "_step"},    int'(bus.upd_step), 0);
        chk({tag, "_en"},      int'(bus.star_en), 1);
        chk({tag, "_bright"},  int'(bus.brightness), 255);
        chk({tag, "_twinkle"}, int'(bus.twinkle_phase), 0);
        chk({tag, "_overrun"}, int'(bus.overrun_cnt), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.fsync = 1'b0; bus.game_state = GAME_START; bus.upd_ack = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        cycle(1'b0, GAME_START, 1'b0);
        rst = 1'b0;
        lit_reset("lit_rst");

        // First PLAY frame: request with step 2 one cycle after fsync, acked next cycle.
        cycle(1'b1, GAME_PLAY, 1'b0);
        chk("lit_play_req",  int'(bus.upd_req), 1);
        chk("lit_play_step", int'(bus.upd_step), 2);
        chk("lit_play_mode", int'(bus.mode), int'(CRUISE));
        cycle(1'b0, GAME_PLAY, 1'b1);
        chk("lit_play_ackclr", int'(bus.upd_req), 0);
        cycle(1'b0, GAME_PLAY, 1'b0);
        cycle(1'b0, GAME_PLAY, 1'b0);
        frame(GAME_PLAY, 1'b1);
        frame(GAME_PLAY, 1'b1);

        // Warp ramp up 2..12, hold, then ramp back down to cruise.
        for (int i = 0; i < 41; i++) begin
            frame(GAME_WARP, 1'b1);
            if (i == 4) chk("lit_warp_step5", int'(bus.upd_step), 3);
        end
        chk("lit_hold_mode", int'(bus.mode), int'(WARP_HOLD));
        chk("lit_hold_step", int'(bus.upd_step), 12);
        frame(GAME_WARP, 1'b1);
        frame(GAME_WARP, 1'b1);
        for (int i = 0; i < 41; i++) begin
            frame(GAME_PLAY, 1'b1);
            if (i == 39) chk("lit_down_step", int'(bus.upd_step), 3);
        end
        chk("lit_down_mode", int'(bus.mode), int'(CRUISE));
        chk("lit_down_step2", int'(bus.upd_step), 2);

        // Back to hold, then game over: fade to dark, then restart.
        for (int i = 0; i < 41; i++) frame(GAME_WARP, 1'b1);
        frame(GAME_OVER, 1'b0);
        chk("lit_fade_req",    int'(bus.upd_req), 0);
        chk("lit_fade_bright", int'(bus.brightness), 247);
        chk("lit_fade_mode",   int'(bus.mode), int'(FADE));
        for (int i = 0; i < 30; i++) frame(GAME_OVER, 1'b0);
        chk("lit_fade31_bright", int'(bus.brightness), 7);
        frame(GAME_OVER, 1'b0);
        chk("lit_dark_bright", int'(bus.brightness), 0);
        chk("lit_dark_mode",   int'(bus.mode), int'(DARK));
        chk("lit_dark_en",     int'(bus.star_en), 0);
        frame(GAME_START, 1'b1);
        chk("lit_restart_mode",   int'(bus.mode), int'(DRIFT));
        chk("lit_restart_bright", int'(bus.brightness), 255);
        chk("lit_restart_en",     int'(bus.star_en), 1);
        chk("lit_restart_step",   int'(bus.upd_step), 1);

        // Fresh reset, then drift: step 1 on odd frames only; twinkle ticks at the 8th fsync.
        rst = 1'b1;
        cycle(1'b0, GAME_START, 1'b0);
        rst = 1'b0;
        lit_reset("lit_rst2");
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, GAME_START, 1'b0);
            chk("lit_drift_req", int'(bus.upd_req), (i % 2 == 0) ? 1 : 0);
            if (i == 6) chk("lit_twinkle7", int'(bus.twinkle_phase), 0);
            if (i == 7) chk("lit_twinkle8", int'(bus.twinkle_phase), 1);
            cycle(1'b0, GAME_START, 1'b1);
            cycle(1'b0, GAME_START, 1'b0);
            cycle(1'b0, GAME_START, 1'b0);
        end

        // Withheld ack: steps merge 2->4->6 with two overruns.
        for (int i = 0; i < 3; i++) frame(GAME_PLAY, 1'b0);
        chk("lit_ovr_step", int'(bus.upd_step), 6);
        chk("lit_ovr_cnt",  int'(bus.overrun_cnt), 2);
        chk("lit_ovr_req",  int'(bus.upd_req), 1);
        cycle(1'b0, GAME_PLAY, 1'b1);
        chk("lit_ovr_clr", int'(bus.upd_req), 0);

        // fsync coincident with ack starts a fresh request without counting an overrun.
        frame(GAME_PLAY, 1'b0);
        frame(GAME_PLAY, 1'b0);
        chk("lit_pre_step", int'(bus.upd_step), 4);
        cycle(1'b1, GAME_PLAY, 1'b1);
        chk("lit_coin_req",  int'(bus.upd_req), 1);
        chk("lit_coin_step", int'(bus.upd_step), 2);
        chk("lit_coin_ovr",  int'(bus.overrun_cnt), 3);
        cycle(1'b0, GAME_PLAY, 1'b1);

        // Reset mid-warp, coincident with fsync and ack.
        for (int i = 0; i < 6; i++) frame(GAME_WARP, 1'b1);
        rst = 1'b1;
        cycle(1'b1, GAME_WARP, 1'b1);
        lit_reset("lit_rst_warp");
        rst = 1'b0;
        cycle(1'b0, GAME_WARP, 1'b0);
        cycle(1'b0, GAME_WARP, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
